// File: rtl/write_back_unit_pkg.sv
// ============================================================================
// Module   : write_back_unit_pkg
// Purpose  : Shared state encoding and constants for the LEGv8 writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package write_back_unit_pkg;

  // Writeback FSM states with fixed encodings so they can be decoded externally
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DRIVE    = 2'd2
  } wb_state_t;

  // XZR: writes to this register are silently dropped
  localparam logic [4:0] ZERO_REG_DEFAULT = 5'd31;

endpackage

`default_nettype wire

// File: rtl/write_back_unit_cycle_counter.sv
// ============================================================================
// Module   : write_back_unit_cycle_counter
// Purpose  : Clearable up-counter with a terminal-count flag. It is shared
//            between the register-write hold window and the load timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_back_unit_cycle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Count every cycle; a clear restarts from zero on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign last = (count == terminal);

endmodule

`default_nettype wire

// File: rtl/write_back_unit.sv
// ============================================================================
// Module   : write_back_unit
// Purpose  : Writeback stage. Accepts an ALU or load result, waits for the
//            D-cache when needed, then holds the register-file write stable
//            for HOLD_CYCLES cycles. Exports busy / pending destination.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module write_back_unit
  import write_back_unit_pkg::*;
#(
  parameter int         HOLD_CYCLES = 6,
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [4:0] ZERO_REG    = ZERO_REG_DEFAULT
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        wbValid,
  output logic        wbReady,
  input  logic        regWriteIn,
  input  logic        memToReg,
  input  logic [4:0]  destReg,
  input  logic [31:0] aluResult,
  input  logic        cacheDataValid,
  input  logic [31:0] cacheReadData,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  output logic        wbBusy,
  output logic [4:0]  wbPendingReg,
  output logic        wbDone,
  output logic        wbError
);

  localparam int CNT_MAX = (HOLD_CYCLES > MEM_TIMEOUT) ? HOLD_CYCLES : MEM_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter value on the edge that ends the phase (hold done / timeout hit)
  localparam logic [CNT_W-1:0] HOLD_TERM    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state;
  logic [4:0]       dest_reg_q;
  logic             cnt_clear;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_terminal;

  assign wbReady = (state == ST_IDLE);

  // Counter restarts whenever a phase begins: idle, load data arrival, or phase end
  assign cnt_clear    = (state == ST_IDLE) ||
                        ((state == ST_WAIT_MEM) && cacheDataValid) ||
                        cnt_last;
  assign cnt_terminal = (state == ST_DRIVE) ? HOLD_TERM : TIMEOUT_TERM;

  write_back_unit_cycle_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_counter (
    .clk      (clock),
    .rst_n    (resetN),
    .clear    (cnt_clear),
    .terminal (cnt_terminal),
    .last     (cnt_last)
  );

  // Writeback FSM with all outputs registered
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= ST_IDLE;
      dest_reg_q    <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      wbBusy        <= 1'b0;
      wbPendingReg  <= ZERO_REG;
      wbDone        <= 1'b0;
      wbError       <= 1'b0;
    end else begin
      wbDone  <= 1'b0;
      wbError <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wbValid) begin
            dest_reg_q <= destReg;
            if (!regWriteIn || (destReg == ZERO_REG)) begin
              // Nothing to write: retire immediately
              wbDone <= 1'b1;
            end else if (memToReg) begin
              state        <= ST_WAIT_MEM;
              wbBusy       <= 1'b1;
              wbPendingReg <= destReg;
            end else begin
              state         <= ST_DRIVE;
              wbBusy        <= 1'b1;
              wbPendingReg  <= destReg;
              regWrite      <= 1'b1;
              writeRegister <= destReg;
              writeData     <= aluResult;
            end
          end
        end
        ST_WAIT_MEM: begin
          // Data arriving on the timeout edge still wins
          if (cacheDataValid) begin
            state         <= ST_DRIVE;
            regWrite      <= 1'b1;
            writeRegister <= dest_reg_q;
            writeData     <= cacheReadData;
          end else if (cnt_last) begin
            state        <= ST_IDLE;
            wbBusy       <= 1'b0;
            wbPendingReg <= ZERO_REG;
            wbError      <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_last) begin
            state         <= ST_IDLE;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            wbBusy        <= 1'b0;
            wbPendingReg  <= ZERO_REG;
            wbDone        <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          regWrite     <= 1'b0;
          writeData    <= '0;
          wbBusy       <= 1'b0;
          wbPendingReg <= ZERO_REG;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_write_back_unit.sv
// ============================================================================
// Module   : tb_write_back_unit
// Purpose  : Directed self-checking bench for write_back_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_write_back_unit;

  localparam int HOLD = 6;
  localparam int TMO  = 16;

  logic        clock;
  logic        resetN;
  logic        wbValid;
  logic        wbReady;
  logic        regWriteIn;
  logic        memToReg;
  logic [4:0]  destReg;
  logic [31:0] aluResult;
  logic        cacheDataValid;
  logic [31:0] cacheReadData;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        wbBusy;
  logic [4:0]  wbPendingReg;
  logic        wbDone;
  logic        wbError;

  int vectors;
  int miscompares;

  write_back_unit #(
    .HOLD_CYCLES (HOLD),
    .MEM_TIMEOUT (TMO),
    .ZERO_REG    (5'd31)
  ) dut (
    .clock          (clock),
    .resetN         (resetN),
    .wbValid        (wbValid),
    .wbReady        (wbReady),
    .regWriteIn     (regWriteIn),
    .memToReg       (memToReg),
    .destReg        (destReg),
    .aluResult      (aluResult),
    .cacheDataValid (cacheDataValid),
    .cacheReadData  (cacheReadData),
    .regWrite       (regWrite),
    .writeRegister  (writeRegister),
    .writeData      (writeData),
    .wbBusy         (wbBusy),
    .wbPendingReg   (wbPendingReg),
    .wbDone         (wbDone),
    .wbError        (wbError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present a transaction at the current negedge
  task automatic present(input logic rw, input logic m2r, input logic [4:0] d, input logic [31:0] a);
    wbValid    = 1'b1;
    regWriteIn = rw;
    memToReg   = m2r;
    destReg    = d;
    aluResult  = a;
  endtask

  // Called at the first negedge after the edge that started DRIVE
  task automatic drive_window(input string tag, input logic [4:0] d, input logic [31:0] v);
    for (int i = 0; i < HOLD; i++) begin
      check_vec({tag, "_regWrite"}, {31'd0, regWrite}, 32'd1);
      check_vec({tag, "_writeRegister"}, {27'd0, writeRegister}, {27'd0, d});
      check_vec({tag, "_writeData"}, writeData, v);
      check_vec({tag, "_pending"}, {27'd0, wbPendingReg}, {27'd0, d});
      check_vec({tag, "_ready_low"}, {31'd0, wbReady}, 32'd0);
      check_vec({tag, "_done_low"}, {31'd0, wbDone}, 32'd0);
      @(negedge clock);
    end
    check_vec({tag, "_end_regWrite"}, {31'd0, regWrite}, 32'd0);
    check_vec({tag, "_end_writeData"}, writeData, 32'd0);
    check_vec({tag, "_end_done"}, {31'd0, wbDone}, 32'd1);
    check_vec({tag, "_end_ready"}, {31'd0, wbReady}, 32'd1);
    check_vec({tag, "_end_busy"}, {31'd0, wbBusy}, 32'd0);
    check_vec({tag, "_end_pending"}, {27'd0, wbPendingReg}, 32'd31);
    check_vec({tag, "_end_error"}, {31'd0, wbError}, 32'd0);
  endtask

  // Called at the first negedge after entering WAIT_MEM; waits n cycles without data
  task automatic wait_idle_mem(input string tag, input int n, input logic [4:0] d);
    for (int i = 0; i < n; i++) begin
      check_vec({tag, "_busy"}, {31'd0, wbBusy}, 32'd1);
      check_vec({tag, "_pending"}, {27'd0, wbPendingReg}, {27'd0, d});
      check_vec({tag, "_regWrite"}, {31'd0, regWrite}, 32'd0);
      check_vec({tag, "_error"}, {31'd0, wbError}, 32'd0);
      if (i != n - 1) @(negedge clock);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    resetN         = 1'b0;
    wbValid        = 1'b0;
    regWriteIn     = 1'b0;
    memToReg       = 1'b0;
    destReg        = '0;
    aluResult      = '0;
    cacheDataValid = 1'b0;
    cacheReadData  = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check_vec("rst_regWrite", {31'd0, regWrite}, 32'd0);
    check_vec("rst_writeData", writeData, 32'd0);
    check_vec("rst_writeRegister", {27'd0, writeRegister}, 32'd0);
    check_vec("rst_busy", {31'd0, wbBusy}, 32'd0);
    check_vec("rst_pending", {27'd0, wbPendingReg}, 32'd31);
    check_vec("rst_done", {31'd0, wbDone}, 32'd0);
    check_vec("rst_error", {31'd0, wbError}, 32'd0);
    check_vec("rst_ready", {31'd0, wbReady}, 32'd1);
    resetN = 1'b1;
    @(negedge clock);

    // 1: ALU write
    present(1'b1, 1'b0, 5'd5, 32'h0000_002A);
    @(negedge clock);
    wbValid = 1'b0;
    drive_window("alu", 5'd5, 32'h0000_002A);
    @(negedge clock);
    check_vec("alu_done_pulse_end", {31'd0, wbDone}, 32'd0);

    // 2: Load with data after 3 cycles
    present(1'b1, 1'b1, 5'd9, 32'h1234_5678);
    @(negedge clock);
    wbValid = 1'b0;
    wait_idle_mem("load_wait", 3, 5'd9);
    cacheDataValid = 1'b1;
    cacheReadData  = 32'hDEAD_BEEF;
    @(negedge clock);
    cacheDataValid = 1'b0;
    cacheReadData  = '0;
    drive_window("load", 5'd9, 32'hDEAD_BEEF);
    @(negedge clock);

    // 3: XZR and no-write retire in one cycle; stray cache valid ignored in IDLE
    present(1'b1, 1'b0, 5'd31, 32'h5555_5555);
    @(negedge clock);
    wbValid = 1'b0;
    check_vec("xzr_done", {31'd0, wbDone}, 32'd1);
    check_vec("xzr_regWrite", {31'd0, regWrite}, 32'd0);
    check_vec("xzr_busy", {31'd0, wbBusy}, 32'd0);
    cacheDataValid = 1'b1;
    @(negedge clock);
    cacheDataValid = 1'b0;
    check_vec("xzr_done_end", {31'd0, wbDone}, 32'd0);
    check_vec("idle_valid_busy", {31'd0, wbBusy}, 32'd0);
    present(1'b0, 1'b0, 5'd4, 32'h6666_6666);
    @(negedge clock);
    wbValid = 1'b0;
    check_vec("nowr_done", {31'd0, wbDone}, 32'd1);
    check_vec("nowr_regWrite", {31'd0, regWrite}, 32'd0);
    check_vec("nowr_pending", {27'd0, wbPendingReg}, 32'd31);
    @(negedge clock);
    check_vec("nowr_done_end", {31'd0, wbDone}, 32'd0);

    // 4a: Load timeout after 16 cycles without data
    present(1'b1, 1'b1, 5'd7, 32'h0);
    @(negedge clock);
    wbValid = 1'b0;
    wait_idle_mem("tmo_wait", TMO, 5'd7);
    @(negedge clock);
    check_vec("tmo_error", {31'd0, wbError}, 32'd1);
    check_vec("tmo_done", {31'd0, wbDone}, 32'd0);
    check_vec("tmo_regWrite", {31'd0, regWrite}, 32'd0);
    check_vec("tmo_ready", {31'd0, wbReady}, 32'd1);
    check_vec("tmo_pending", {27'd0, wbPendingReg}, 32'd31);
    @(negedge clock);
    check_vec("tmo_error_end", {31'd0, wbError}, 32'd0);

    // 4b: Data on the 16th cycle beats the timeout
    present(1'b1, 1'b1, 5'd8, 32'h0);
    @(negedge clock);
    wbValid = 1'b0;
    wait_idle_mem("late_wait", TMO, 5'd8);
    cacheDataValid = 1'b1;
    cacheReadData  = 32'hCAFE_F00D;
    @(negedge clock);
    cacheDataValid = 1'b0;
    check_vec("late_error", {31'd0, wbError}, 32'd0);
    drive_window("late", 5'd8, 32'hCAFE_F00D);
    @(negedge clock);

    // 5: Asynchronous reset in the middle of DRIVE
    present(1'b1, 1'b0, 5'd17, 32'hA5A5_A5A5);
    @(negedge clock);
    wbValid = 1'b0;
    repeat (2) @(negedge clock);
    check_vec("rstmid_regWrite_before", {31'd0, regWrite}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    check_vec("rstmid_regWrite", {31'd0, regWrite}, 32'd0);
    check_vec("rstmid_writeData", writeData, 32'd0);
    check_vec("rstmid_writeRegister", {27'd0, writeRegister}, 32'd0);
    check_vec("rstmid_busy", {31'd0, wbBusy}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < HOLD + 2; i++) begin
      @(negedge clock);
      check_vec("rstmid_ready", {31'd0, wbReady}, 32'd1);
      check_vec("rstmid_no_done", {31'd0, wbDone}, 32'd0);
      check_vec("rstmid_no_write", {31'd0, regWrite}, 32'd0);
    end

    // 6: Back-to-back ALU results with wbValid held high
    present(1'b1, 1'b0, 5'd3, 32'h0000_0111);
    @(negedge clock);
    present(1'b1, 1'b0, 5'd12, 32'h0000_0222);
    drive_window("b2b_first", 5'd3, 32'h0000_0111);
    @(negedge clock);
    wbValid = 1'b0;
    drive_window("b2b_second", 5'd12, 32'h0000_0222);
    @(negedge clock);
    check_vec("b2b_idle_regWrite", {31'd0, regWrite}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
